crc5_r: RTL and testbench

//  Token-packet receiver and CRC5 checker; the receive-side counterpart of the token transmitter.

---
 rtl/crc5_r_pkg.sv | 35 +++
 rtl/crc5_r_chk.sv | 28 ++
 rtl/crc5_r.sv | 168 ++++++++++++++++
 tb/tb_crc5_r.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc5_r_pkg.sv
// Shared token-link definitions: PID codes, CRC5 constants and error codes
// used by both the token transmitter and the token receiver.
package crc5_r_pkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   // x^5 + x^2 + 1, register shifts towards bit 4
   localparam logic [4:0] CRC5_POLY     = 5'b00101;
   localparam logic [4:0] CRC5_INIT     = 5'b11111;
   localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

   typedef enum logic [1:0] {
      ERR_PID = 2'd0,
      ERR_LEN = 2'd1,
      ERR_CRC = 2'd2
   } err_code_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_B1   = 2'd1,
      ST_B2   = 2'd2
   } rx_state_e;

   function automatic logic is_token_pid(input logic [3:0] pid);
      return (pid == PID_OUT) || (pid == PID_IN) ||
             (pid == PID_SETUP) || (pid == PID_SOF);
   endfunction

endpackage

// File: rtl/crc5_r_chk.sv
// Combinational CRC5 residual check over the 16 token bits (11 data bits
// followed by the 5-bit CRC field), bit 0 being first on the wire.
module crc5_chk
   import crc5_r_pkg::*;
(
   input  logic [15:0] bits,
   output logic [4:0]  residual,
   output logic        ok
);

   // The loop unrolls into a flat XOR network; nothing here is sequential.
   function automatic logic [4:0] crc5_residual(input logic [15:0] d);
      logic [4:0] c;
      logic       fb;
      c = CRC5_INIT;
      for (int i = 0; i < 16; i++) begin
         fb = c[4] ^ d[i];
         c  = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
      end
      return c;
   endfunction

   always_comb begin
      residual = crc5_residual(bits);
      ok       = (residual == CRC5_RESIDUAL);
   end

endmodule

// File: rtl/crc5_r.sv
// Token-packet receiver: validates the PID, reassembles addr/endp, checks CRC5
// and hands tokens (or one-byte handshake PIDs) to the protocol controller.
module crc5_r
   import crc5_r_pkg::*;
#(
   parameter int ADDR_FILTER = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] dev_addr,
   input  logic [7:0] rx_from_data,
   input  logic       rx_from_sop,
   input  logic       rx_from_eop,
   input  logic       rx_from_valid,
   output logic       rx_from_ready,
   output logic [3:0] rx_pid,
   output logic [6:0] rx_addr,
   output logic [3:0] rx_endp,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [3:0] rx_con_pid,
   output logic       rx_con_pid_en,
   output logic       rx_err,
   output logic [1:0] rx_err_code
);

   rx_state_e  state_q, state_n;
   logic [3:0] pid_q;
   logic [6:0] addr_q;
   logic       endp0_q;

   logic       acc;
   logic       pid_ok;
   logic       crc_ok;
   logic [4:0] crc_res;
   logic       addr_pass;
   logic       err_ev;
   err_code_e  err_code_ev;
   logic       con_ev;
   logic       tok_ev;
   logic       ld_pid;
   logic       ld_b1;

   assign rx_from_ready = !rx_valid;
   assign acc           = rx_from_valid & rx_from_ready;
   assign pid_ok        = (rx_from_data[7:4] == ~rx_from_data[3:0]);

   crc5_chk u_chk (
      .bits     ({rx_from_data[7:3], rx_from_data[2:0], endp0_q, addr_q}),
      .residual (crc_res),
      .ok       (crc_ok)
   );

   always_comb begin
      addr_pass = 1'b1;
      if (ADDR_FILTER != 0)
         addr_pass = (pid_q == PID_SOF) || (addr_q == dev_addr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_n;
   end

   always_comb begin
      state_n     = state_q;
      err_ev      = 1'b0;
      err_code_ev = ERR_PID;
      con_ev      = 1'b0;
      tok_ev      = 1'b0;
      ld_pid      = 1'b0;
      ld_b1       = 1'b0;
      if (acc) begin
         // A sop mid-packet aborts the packet; the byte then starts a new one.
         if (state_q != ST_IDLE && rx_from_sop) begin
            err_ev      = 1'b1;
            err_code_ev = ERR_LEN;
         end
         if (state_q == ST_IDLE || rx_from_sop) begin
            state_n = ST_IDLE;
            if (rx_from_sop) begin
               if (!pid_ok) begin
                  err_ev      = 1'b1;
                  err_code_ev = ERR_PID;
               end else if (rx_from_eop) begin
                  con_ev = 1'b1;
               end else if (is_token_pid(rx_from_data[3:0])) begin
                  ld_pid  = 1'b1;
                  state_n = ST_B1;
               end
            end
         end else begin
            case (state_q)
               ST_B1: begin
                  ld_b1 = 1'b1;
                  if (rx_from_eop) begin
                     err_ev      = 1'b1;
                     err_code_ev = ERR_LEN;
                     state_n     = ST_IDLE;
                  end else begin
                     state_n = ST_B2;
                  end
               end
               ST_B2: begin
                  state_n = ST_IDLE;
                  if (!rx_from_eop) begin
                     err_ev      = 1'b1;
                     err_code_ev = ERR_LEN;
                  end else if (!crc_ok) begin
                     err_ev      = 1'b1;
                     err_code_ev = ERR_CRC;
                  end else if (addr_pass) begin
                     tok_ev = 1'b1;
                  end
               end
               default: state_n = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pid_q   <= 4'd0;
         addr_q  <= 7'd0;
         endp0_q <= 1'b0;
      end else begin
         if (ld_pid)
            pid_q <= rx_from_data[3:0];
         if (ld_b1) begin
            addr_q  <= rx_from_data[6:0];
            endp0_q <= rx_from_data[7];
         end
      end
   end

   // Output register stage: strobes last one cycle, token fields hold until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_pid        <= 4'd0;
         rx_addr       <= 7'd0;
         rx_endp       <= 4'd0;
         rx_valid      <= 1'b0;
         rx_con_pid    <= 4'd0;
         rx_con_pid_en <= 1'b0;
         rx_err        <= 1'b0;
         rx_err_code   <= 2'd0;
      end else begin
         rx_err        <= err_ev;
         rx_con_pid_en <= con_ev;
         if (err_ev)
            rx_err_code <= err_code_ev;
         if (con_ev)
            rx_con_pid <= rx_from_data[3:0];
         if (tok_ev) begin
            rx_valid <= 1'b1;
            rx_pid   <= pid_q;
            rx_addr  <= addr_q;
            rx_endp  <= {rx_from_data[2:0], endp0_q};
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc5_r.sv
// Directed bench for crc5_r: a table of three-byte token packets plus
// hand-written sequences for handshakes, framing errors, backpressure and reset.
module tb_crc5_r;

   logic       clk;
   logic       rst_n;
   logic [6:0] dev_addr;
   logic [7:0] rx_from_data;
   logic       rx_from_sop;
   logic       rx_from_eop;
   logic       rx_from_valid;
   logic       rx_from_ready;
   logic [3:0] rx_pid;
   logic [6:0] rx_addr;
   logic [3:0] rx_endp;
   logic       rx_valid;
   logic       rx_ready;
   logic [3:0] rx_con_pid;
   logic       rx_con_pid_en;
   logic       rx_err;
   logic [1:0] rx_err_code;

   int n_checks = 0;
   int n_fail   = 0;
   int err_seen = 0;
   int con_seen = 0;

   crc5_r #(.ADDR_FILTER(1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dev_addr      (dev_addr),
      .rx_from_data  (rx_from_data),
      .rx_from_sop   (rx_from_sop),
      .rx_from_eop   (rx_from_eop),
      .rx_from_valid (rx_from_valid),
      .rx_from_ready (rx_from_ready),
      .rx_pid        (rx_pid),
      .rx_addr       (rx_addr),
      .rx_endp       (rx_endp),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_con_pid    (rx_con_pid),
      .rx_con_pid_en (rx_con_pid_en),
      .rx_err        (rx_err),
      .rx_err_code   (rx_err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_err) err_seen++;
      if (rx_con_pid_en) con_seen++;
   end

   typedef struct {
      logic [7:0] b0, b1, b2;
      logic [6:0] dev;
      logic       exp_valid;
      logic [3:0] exp_pid;
      logic [6:0] exp_addr;
      logic [3:0] exp_endp;
      logic       exp_err;
      logic [1:0] exp_code;
   } vec_t;

   localparam int NV = 7;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
      int n;
      n = 0;
      @(negedge clk);
      rx_from_data  = d;
      rx_from_sop   = s;
      rx_from_eop   = e;
      rx_from_valid = 1'b1;
      while (!rx_from_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", rx_from_ready, 1);
      @(posedge clk);
      #1;
      rx_from_valid = 1'b0;
      rx_from_sop   = 1'b0;
      rx_from_eop   = 1'b0;
   endtask

   task automatic clear_seen();
      @(posedge clk);
      #1;
      err_seen = 0;
      con_seen = 0;
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      dev_addr      = 7'd0;
      rx_from_data  = 8'h00;
      rx_from_sop   = 1'b0;
      rx_from_eop   = 1'b0;
      rx_from_valid = 1'b0;
      rx_ready      = 1'b0;

      //             b0     b1     b2    dev   vld  pid    addr   endp   err  code
      tbl[0] = '{8'h2D, 8'h00, 8'h10, 7'd0, 1'b1, 4'hD, 7'd0, 4'd0, 1'b0, 2'd0};
      tbl[1] = '{8'h2D, 8'h00, 8'h18, 7'd0, 1'b0, 4'h0, 7'd0, 4'd0, 1'b1, 2'd2};
      tbl[2] = '{8'h69, 8'h00, 8'h10, 7'd5, 1'b0, 4'h0, 7'd0, 4'd0, 1'b0, 2'd0};
      tbl[3] = '{8'hA5, 8'h00, 8'h10, 7'd5, 1'b1, 4'h5, 7'd0, 4'd0, 1'b0, 2'd0};
      tbl[4] = '{8'hE1, 8'h05, 8'hD0, 7'd5, 1'b1, 4'h1, 7'd5, 4'd0, 1'b0, 2'd0};
      tbl[5] = '{8'hE1, 8'h05, 8'hD0, 7'd0, 1'b0, 4'h0, 7'd0, 4'd0, 1'b0, 2'd0};
      tbl[6] = '{8'hE1, 8'h85, 8'hD0, 7'd5, 1'b0, 4'h0, 7'd0, 4'd0, 1'b1, 2'd2};

      repeat (3) @(negedge clk);
      #1;
      chk("reset rx_from_ready", rx_from_ready, 1);
      chk("reset rx_valid", rx_valid, 0);
      chk("reset rx_err", rx_err, 0);
      chk("reset rx_err_code", rx_err_code, 0);
      chk("reset rx_con_pid_en", rx_con_pid_en, 0);
      chk("reset rx_pid", rx_pid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         dev_addr = tbl[i].dev;
         clear_seen();
         send_byte(tbl[i].b0, 1'b1, 1'b0);
         send_byte(tbl[i].b1, 1'b0, 1'b0);
         send_byte(tbl[i].b2, 1'b0, 1'b1);
         settle();
         chk($sformatf("vec%0d rx_valid", i), rx_valid, tbl[i].exp_valid);
         chk($sformatf("vec%0d err_count", i), err_seen, tbl[i].exp_err ? 1 : 0);
         chk($sformatf("vec%0d con_count", i), con_seen, 0);
         if (tbl[i].exp_err)
            chk($sformatf("vec%0d err_code", i), rx_err_code, tbl[i].exp_code);
         if (tbl[i].exp_valid) begin
            chk($sformatf("vec%0d rx_pid", i), rx_pid, tbl[i].exp_pid);
            chk($sformatf("vec%0d rx_addr", i), rx_addr, tbl[i].exp_addr);
            chk($sformatf("vec%0d rx_endp", i), rx_endp, tbl[i].exp_endp);
            chk($sformatf("vec%0d rx_from_ready held", i), rx_from_ready, 0);
         end
         rx_ready = 1'b1;
         @(negedge clk);
         #1;
         chk($sformatf("vec%0d rx_valid cleared", i), rx_valid, 0);
         rx_ready = 1'b0;
      end

      // handshake ACK
      clear_seen();
      send_byte(8'hD2, 1'b1, 1'b1);
      settle();
      chk("ack con_count", con_seen, 1);
      chk("ack rx_con_pid", rx_con_pid, 4'h2);
      chk("ack err_count", err_seen, 0);
      chk("ack rx_valid", rx_valid, 0);

      // eop on the address byte
      clear_seen();
      send_byte(8'h2D, 1'b1, 1'b0);
      send_byte(8'h00, 1'b0, 1'b1);
      settle();
      chk("short err_count", err_seen, 1);
      chk("short err_code", rx_err_code, 1);

      // bad PID check
      clear_seen();
      send_byte(8'h2A, 1'b1, 1'b0);
      settle();
      chk("badpid err_count", err_seen, 1);
      chk("badpid err_code", rx_err_code, 0);
      chk("badpid con_count", con_seen, 0);

      // backpressure: token pending, a new byte must wait
      dev_addr = 7'd0;
      clear_seen();
      send_byte(8'h2D, 1'b1, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h10, 1'b0, 1'b1);
      @(negedge clk);
      rx_from_data  = 8'hFF;
      rx_from_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("bp rx_from_ready", rx_from_ready, 0);
      chk("bp rx_valid", rx_valid, 1);
      chk("bp rx_pid", rx_pid, 4'hD);
      chk("bp rx_addr", rx_addr, 0);
      rx_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp valid drop", rx_valid, 0);
      chk("bp ready back", rx_from_ready, 1);
      @(posedge clk);
      #1;
      rx_from_valid = 1'b0;
      rx_ready      = 1'b0;
      settle();
      chk("bp junk err_count", err_seen, 0);
      chk("bp junk valid", rx_valid, 0);

      // sop arriving in B2 aborts and restarts as IN token
      clear_seen();
      send_byte(8'h2D, 1'b1, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h69, 1'b1, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h10, 1'b0, 1'b1);
      settle();
      chk("abort err_count", err_seen, 1);
      chk("abort err_code", rx_err_code, 1);
      chk("abort rx_valid", rx_valid, 1);
      chk("abort rx_pid", rx_pid, 4'h9);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;

      // async reset mid-token discards the partial packet
      clear_seen();
      send_byte(8'h2D, 1'b1, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst err_code", rx_err_code, 0);
      chk("midrst rx_from_ready", rx_from_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'h10, 1'b0, 1'b1);
      settle();
      chk("midrst rx_valid", rx_valid, 0);
      chk("midrst err_count", err_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
